// File: rtl/uart_rx_os4_if.sv
// Bus-side holding-register port of the 4x-oversampling UART receiver.
// The receiver drives the byte and status; the consumer drives accept and overrun-clear.
interface uart_rx_os4_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_ovr;
  logic                 ovr_clr;

  modport master (
    output rx_data, rx_ferr, rx_valid, rx_ovr,
    input  rx_ready, ovr_clr
  );

  modport slave (
    input  rx_data, rx_ferr, rx_valid, rx_ovr,
    output rx_ready, ovr_clr
  );
endinterface

// File: rtl/uart_rx_os4.sv
// 8N1 UART receiver sampling rxd on a 4x baud strobe, with a one-entry
// valid/ready holding register, per-byte frame error and sticky overrun.
module uart_rx_os4 #(
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baudtick_i,
  input  logic           rxd_i,
  output logic           busy_o,
  uart_rx_os4_if.master  rx_if
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [1:0]           tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 busy_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic rxd_s, xfer, stop_smp, load, ovr_set, shift_en;

  always_comb begin
    rxd_s    = sync_q[1];
    xfer     = valid_q & rx_if.rx_ready;
    stop_smp = baudtick_i && (state_q == STOP) && (tick_cnt_q == 2'd3);
    shift_en = baudtick_i && (state_q == DATA) && (tick_cnt_q == 2'd3);
    load     = stop_smp && (!valid_q || xfer);
    ovr_set  = stop_smp && valid_q && !xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      tick_cnt_q <= 2'd0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      if (baudtick_i) begin
        case (state_q)
          IDLE: if (!rxd_s) begin
            state_q    <= START;
            tick_cnt_q <= 2'd0;
            busy_q     <= 1'b1;
          end
          START: begin
            if (tick_cnt_q == 2'd2) begin
              if (rxd_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= DATA;
                tick_cnt_q <= 2'd0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 2'd1;
            end
          end
          DATA: begin
            tick_cnt_q <= tick_cnt_q + 2'd1;
            if (tick_cnt_q == 2'd3) begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == LAST_BIT) begin
                state_q    <= STOP;
                tick_cnt_q <= 2'd0;
              end
            end
          end
          STOP: begin
            tick_cnt_q <= tick_cnt_q + 2'd1;
            if (tick_cnt_q == 2'd3) begin
              // A low stop bit parks in BRK so a held-low line is not re-read as start bits
              if (rxd_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= BRK;
              end
            end
          end
          BRK: if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
  end

  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shift_q;
      ferr_d  = !rxd_s;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (ovr_set)            ovr_d = 1'b1;
    else if (rx_if.ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_ferr  = ferr_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.rx_ovr   = ovr_q;
  assign busy_o         = busy_q;
endmodule

// File: tb/tb_uart_rx_os4.sv
// Scoreboard bench for uart_rx_os4: frames are driven at 4 ticks/bit, 10 clk/tick,
// expected bytes are queued as sent and compared when the holding register presents them.
module tb_uart_rx_os4;
  logic clk = 1'b0;
  logic rst;
  logic baudtick;
  logic rxd;
  logic busy;
  int   tcnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [8:0] exp_q[$];

  uart_rx_os4_if #(.DATA_BITS(8)) bus ();

  uart_rx_os4 #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .baudtick_i (baudtick),
    .rxd_i      (rxd),
    .busy_o     (busy),
    .rx_if      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    baudtick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt == 9) ? 0 : tcnt + 1;
      baudtick = (tcnt == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic align();
    @(posedge clk);
    while (baudtick !== 1'b1) @(posedge clk);
    repeat (5) @(negedge clk);
  endtask

  // Drives one 8N1 frame; samples the holding register just before and after the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy, input logic clr,
                            output logic [7:0] d_pre, output logic v_pre, output logic v_post);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (40) @(negedge clk);
    end
    rxd = stop;
    repeat (35) @(negedge clk);
    d_pre = bus.rx_data;
    v_pre = bus.rx_valid;
    bus.rx_ready = rdy;
    bus.ovr_clr  = clr;
    @(negedge clk);
    v_post = bus.rx_valid;
    bus.rx_ready = 1'b0;
    bus.ovr_clr  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ready();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; bus.rx_ready = 1'b0; bus.ovr_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.rx_ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", bus.rx_ferr); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.rx_ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", bus.rx_ovr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [7:0] dp; logic vp, vq;
    align();
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    n_cmp++; if (vp !== 1'b0) begin n_err++; $display("FAIL single_valid_before: got %b want 0", vp); end
    n_cmp++; if (vq !== 1'b1) begin n_err++; $display("FAIL single_valid_after: got %b want 1", vq); end
    n_cmp++; if (bus.rx_data !== exp_q[0][7:0]) begin n_err++; $display("FAIL single_data: got %h want %h", bus.rx_data, exp_q[0][7:0]); end
    n_cmp++; if (bus.rx_ferr !== exp_q[0][8]) begin n_err++; $display("FAIL single_ferr: got %b want %b", bus.rx_ferr, exp_q[0][8]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    pulse_ready();
    void'(exp_q.pop_front());
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drain: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold: got %h want a5", bus.rx_data); end
  endtask

  task automatic test_false_start();
    align();
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL false_busy_start: got %b want 1", busy); end
    repeat (60) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL false_busy_drop: got %b want 0", busy); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL false_valid: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_frame_error_break();
    logic [7:0] dp; logic vp, vq;
    align();
    exp_q.push_back({1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, dp, vp, vq);
    n_cmp++; if (bus.rx_data !== exp_q[0][7:0]) begin n_err++; $display("FAIL ferr_data: got %h want %h", bus.rx_data, exp_q[0][7:0]); end
    n_cmp++; if (bus.rx_ferr !== exp_q[0][8]) begin n_err++; $display("FAIL ferr_flag: got %b want %b", bus.rx_ferr, exp_q[0][8]); end
    pulse_ready();
    void'(exp_q.pop_front());
    repeat (400) @(negedge clk);
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL break_no_load: got %b want 0", bus.rx_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy: got %b want 1", busy); end
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_release: got %b want 0", busy); end
    align();
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    for (int k = 0; k < 100 && bus.rx_valid !== 1'b1; k++) @(negedge clk);
    n_cmp++; if (bus.rx_valid !== 1'b1) begin n_err++; $display("FAIL after_break_valid: got %b want 1", bus.rx_valid); end
    n_cmp++; if ({bus.rx_ferr, bus.rx_data} !== exp_q[0]) begin n_err++; $display("FAIL after_break_byte: got %h want %h", {bus.rx_ferr, bus.rx_data}, exp_q[0]); end
    pulse_ready();
    void'(exp_q.pop_front());
  endtask

  task automatic test_overrun();
    logic [7:0] dp; logic vp, vq;
    align();
    exp_q.push_back({1'b0, 8'h01});
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    n_cmp++; if (bus.rx_data !== exp_q[0][7:0]) begin n_err++; $display("FAIL ovr_keep_old: got %h want %h", bus.rx_data, exp_q[0][7:0]); end
    n_cmp++; if (bus.rx_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", bus.rx_ovr); end
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rx_ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", bus.rx_ovr); end
    pulse_ready();
    void'(exp_q.pop_front());
    align();
    exp_q.push_back({1'b0, 8'h01});
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    exp_q.push_back({1'b0, 8'h02});
    send_frame(8'h02, 1'b1, 1'b1, 1'b0, dp, vp, vq);
    n_cmp++; if (dp !== exp_q[0][7:0]) begin n_err++; $display("FAIL same_cycle_xfer_data: got %h want %h", dp, exp_q[0][7:0]); end
    void'(exp_q.pop_front());
    n_cmp++; if ({vp, vq} !== 2'b11) begin n_err++; $display("FAIL same_cycle_valid: got %b want 11", {vp, vq}); end
    n_cmp++; if (bus.rx_data !== exp_q[0][7:0]) begin n_err++; $display("FAIL same_cycle_load: got %h want %h", bus.rx_data, exp_q[0][7:0]); end
    n_cmp++; if (bus.rx_ovr !== 1'b0) begin n_err++; $display("FAIL same_cycle_ovr: got %b want 0", bus.rx_ovr); end
  endtask

  task automatic test_ovr_collision();
    logic [7:0] dp; logic vp, vq;
    align();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, dp, vp, vq);
    n_cmp++; if (bus.rx_ovr !== 1'b1) begin n_err++; $display("FAIL collision_ovr: got %b want 1", bus.rx_ovr); end
    n_cmp++; if (bus.rx_data !== exp_q[0][7:0]) begin n_err++; $display("FAIL collision_data: got %h want %h", bus.rx_data, exp_q[0][7:0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] dp; logic vp, vq;
    align();
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (180) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.rx_ovr !== 1'b0) begin n_err++; $display("FAIL midrst_ovr: got %b want 0", bus.rx_ovr); end
    n_cmp++; if ({bus.rx_ferr, busy} !== 2'b00) begin n_err++; $display("FAIL midrst_ferr_busy: got %b want 00", {bus.rx_ferr, busy}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    align();
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, dp, vp, vq);
    for (int k = 0; k < 100 && bus.rx_valid !== 1'b1; k++) @(negedge clk);
    n_cmp++; if (bus.rx_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid: got %b want 1", bus.rx_valid); end
    n_cmp++; if ({bus.rx_ferr, bus.rx_data} !== exp_q[0]) begin n_err++; $display("FAIL post_rst_byte: got %h want %h", {bus.rx_ferr, bus.rx_data}, exp_q[0]); end
    pulse_ready();
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_error_break();
    test_overrun();
    test_ovr_collision();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
